// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// ---------------------------------------------------------------------------
// Fills program memory from a framed byte stream while the CPU is held.
// It is the write-side partner of the fetch path, which only reads.
//
// Frame format on the byte stream:
//   COUNT (N words, 0 means DEPTH), then N*BYTES data bytes, then CHK.
//   Data bytes are little-endian within each word.
//   The frame is good when COUNT + all data bytes + CHK == 0 (mod 256).
//
// Handshake (in_valid / in_ready):
//   A byte transfers on a rising edge where in_valid && in_ready are both 1.
//   in_ready depends only on the FSM state, never on in_valid.
//   in_data is ignored on every other edge.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load_start     one-cycle pulse that starts a frame (IDLE/DONE/ERR only)
//   in_valid       stream byte valid
//   in_data        stream byte
//   in_ready       loader accepts a byte this cycle
//   mem_wen        one-cycle program memory write strobe
//   mem_addr       write address (holds its last value outside a write)
//   mem_wdata      write data    (holds its last value outside a write)
//   cpu_hold       keeps the CPU in reset while a load runs or has failed
//   busy           frame in progress
//   done           last frame finished with a good checksum (sticky)
//   err            last frame failed its checksum (sticky)
//   words_loaded   words written in the current or last frame
//   state_dbg      current FSM state encoding, for debug and checkers
// ---------------------------------------------------------------------------
module prog_mem_loader #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADD_WIDTH:0]   words_loaded,
  output logic [2:0]           state_dbg
);

  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e               state_q, state_d;

  logic [ADD_WIDTH-1:0] addr_q;
  logic [ADD_WIDTH:0]   words_q;
  logic [ADD_WIDTH:0]   rem_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           sum_q;
  logic [WIDTH-1:0]     word_q;
  logic                 done_q;

  logic                 accept;
  logic                 start;
  logic                 last_byte;
  logic                 last_word;
  logic [7:0]           sum_next;

  // A transfer needs both sides; in_ready is a pure function of state.
  assign accept    = in_valid && in_ready;
  // load_start only counts when no frame is running.
  assign start     = load_start &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign last_byte = (idx_q == IDX_W'(BYTES - 1));
  assign last_word = (rem_q == (ADD_WIDTH+1)'(1));
  assign sum_next  = sum_q + in_data;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_COUNT : S_IDLE;
      end
      S_COUNT: begin
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) state_d = (sum_next == 8'd0) ? S_DONE : S_ERR;
      end
      S_ERR: begin
        if (start) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  // err and cpu_hold follow the ERR state directly: ERR is only left on a
  // new load_start or rst, which is exactly when err must clear.
  always_comb begin
    in_ready = 1'b0;
    mem_wen  = 1'b0;
    busy     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b0;
    case (state_q)
      S_COUNT, S_DATA, S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_WRITE: begin
        mem_wen  = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign done         = done_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = word_q;
  assign words_loaded = words_q;
  assign state_dbg    = state_q;

  // -------------------------------------------------------------------------
  // Datapath: address, counters, checksum and word assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      words_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      addr_q  <= '0;
      words_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_COUNT: begin
          if (accept) begin
            // COUNT of zero stands for a full memory image.
            rem_q <= (in_data == 8'd0) ? (ADD_WIDTH+1)'(DEPTH)
                                       : (ADD_WIDTH+1)'(in_data);
            sum_q <= sum_next;
            idx_q <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            for (int k = 0; k < BYTES; k++) begin
              if (idx_q == IDX_W'(k)) word_q[8*k +: 8] <= in_data;
            end
            sum_q <= sum_next;
            idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
          end
        end
        S_WRITE: begin
          words_q <= words_q + (ADD_WIDTH+1)'(1);
          rem_q   <= rem_q - (ADD_WIDTH+1)'(1);
          // The last write of a full-depth frame sits at DEPTH-1; do not
          // step past it so the address never wraps to 0.
          if (!last_word) addr_q <= addr_q + ADD_WIDTH'(1);
        end
        S_CHECK: begin
          if (accept) begin
            sum_q <= sum_next;
            if (sum_next == 8'd0) done_q <= 1'b1;
          end
        end
        default: begin
          sum_q <= sum_q;
        end
      endcase
    end
  end

endmodule
